// File: rtl/bla_pkg.sv
// Shared definitions for the Bresenham line engine: coordinate width,
// signed error widths and the engine state encoding.
package bla_pkg;

    localparam int COORD_W = 8;
    // err spans roughly -2^COORD_W .. +2^COORD_W, e2 doubles that.
    localparam int ERR_W   = COORD_W + 2;
    localparam int E2_W    = COORD_W + 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_PLOT     = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_LOW = 3'd4
    } bla_eng_state_t;

endpackage

// File: rtl/bresenham_line_engine_if.sv
// Pixel stream from the line engine to the frame-buffer writer.
// Handshake: the engine (master) holds pix_wr high with px/py stable until
// the writer (slave) returns pix_ready in the same cycle; a pixel transfers
// on every rising clk edge where pix_wr && pix_ready. pix_wr never depends
// combinationally on pix_ready.
interface bresenham_line_engine_if #(
    parameter int COORD_W = 8
) ();

    logic [COORD_W-1:0] px;
    logic [COORD_W-1:0] py;
    logic               pix_wr;
    logic               pix_ready;

    modport master (
        output px,
        output py,
        output pix_wr,
        input  pix_ready
    );

    modport slave (
        input  px,
        input  py,
        input  pix_wr,
        output pix_ready
    );

endinterface

// File: rtl/bresenham_step.sv
// One combinational Bresenham step: given the running error term and
// current point, produce the error and point for the next pixel. Both the
// x and y tests use the same e2, so a diagonal move happens in one step.
module bresenham_step
    import bla_pkg::*;
#(
    parameter int COORD_W = bla_pkg::COORD_W
) (
    input  logic signed [COORD_W+1:0] err,
    input  logic        [COORD_W:0]   dx,
    input  logic signed [COORD_W+1:0] dy,
    input  logic                      sx,
    input  logic                      sy,
    input  logic        [COORD_W-1:0] cur_x,
    input  logic        [COORD_W-1:0] cur_y,
    output logic signed [COORD_W+1:0] err_next,
    output logic        [COORD_W-1:0] x_next,
    output logic        [COORD_W-1:0] y_next
);

    logic signed [COORD_W+2:0] e2;
    logic signed [COORD_W+2:0] dx_ext;
    logic signed [COORD_W+2:0] dy_ext;
    logic                      step_x;
    logic                      step_y;

    // sx/sy = 1 means step in the negative direction.
    always_comb begin
        e2     = $signed({err, 1'b0});
        dx_ext = $signed({2'b00, dx});
        dy_ext = $signed({dy[COORD_W+1], dy});
        step_x = (e2 >= dy_ext);
        step_y = (e2 <= dx_ext);

        err_next = err;
        if (step_x) begin
            err_next = err_next + dy;
        end
        if (step_y) begin
            err_next = err_next + $signed({1'b0, dx});
        end

        x_next = cur_x;
        if (step_x) begin
            x_next = sx ? (cur_x - COORD_W'(1)) : (cur_x + COORD_W'(1));
        end

        y_next = cur_y;
        if (step_y) begin
            y_next = sy ? (cur_y - COORD_W'(1)) : (cur_y + COORD_W'(1));
        end
    end

endmodule

// File: rtl/bresenham_line_engine.sv
// Rasterises one line segment per draw_en request and streams its pixels
// over the pixel interface. draw_done pulses once after the last pixel is
// accepted; WAIT_LOW swallows a request still held from the finished line.
module bresenham_line_engine
    import bla_pkg::*;
#(
    parameter int COORD_W = bla_pkg::COORD_W
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                draw_en,
    input  logic [COORD_W-1:0]  x0,
    input  logic [COORD_W-1:0]  y0,
    input  logic [COORD_W-1:0]  x1,
    input  logic [COORD_W-1:0]  y1,
    output logic                draw_done,
    output logic                busy,
    output bla_eng_state_t      state_dbg,
    bresenham_line_engine_if.master pix
);

    bla_eng_state_t             state;
    logic [COORD_W-1:0]         x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0]         cur_x, cur_y;
    logic [COORD_W:0]           dx_q;
    logic signed [COORD_W+1:0]  dy_q;
    logic signed [COORD_W+1:0]  err_q;
    logic                       sx_q, sy_q;
    logic [COORD_W-1:0]         px_q, py_q;
    logic                       pix_wr_q;
    logic                       done_q;

    logic [COORD_W-1:0]         adx, ady;
    logic signed [COORD_W+1:0]  dy_init;
    logic signed [COORD_W+1:0]  err_init;
    logic signed [COORD_W+1:0]  err_next;
    logic [COORD_W-1:0]         x_next, y_next;

    // Setup terms for INIT, derived from the latched endpoints.
    always_comb begin
        adx      = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ady      = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        dy_init  = -$signed({2'b00, ady});
        err_init = $signed({2'b00, adx}) + dy_init;
    end

    bresenham_step #(
        .COORD_W (COORD_W)
    ) u_step (
        .err      (err_q),
        .dx       (dx_q),
        .dy       (dy_q),
        .sx       (sx_q),
        .sy       (sy_q),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .err_next (err_next),
        .x_next   (x_next),
        .y_next   (y_next)
    );

    // Engine FSM with registered pixel/done outputs; abort beats acceptance.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            pix_wr_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (draw_en) begin
                        x0_q  <= x0;
                        y0_q  <= y0;
                        x1_q  <= x1;
                        y1_q  <= y1;
                        state <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (!draw_en) begin
                        state <= ST_IDLE;
                    end else begin
                        dx_q     <= {1'b0, adx};
                        dy_q     <= dy_init;
                        err_q    <= err_init;
                        sx_q     <= !(x0_q < x1_q);
                        sy_q     <= !(y0_q < y1_q);
                        cur_x    <= x0_q;
                        cur_y    <= y0_q;
                        px_q     <= x0_q;
                        py_q     <= y0_q;
                        pix_wr_q <= 1'b1;
                        state    <= ST_PLOT;
                    end
                end
                ST_PLOT: begin
                    if (!draw_en) begin
                        pix_wr_q <= 1'b0;
                        px_q     <= '0;
                        py_q     <= '0;
                        state    <= ST_IDLE;
                    end else if (pix.pix_ready) begin
                        if (cur_x == x1_q && cur_y == y1_q) begin
                            pix_wr_q <= 1'b0;
                            px_q     <= '0;
                            py_q     <= '0;
                            done_q   <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            err_q <= err_next;
                            cur_x <= x_next;
                            cur_y <= y_next;
                            px_q  <= x_next;
                            py_q  <= y_next;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!draw_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix.px     = px_q;
    assign pix.py     = py_q;
    assign pix.pix_wr = pix_wr_q;
    assign draw_done  = done_q;
    assign busy       = (state != ST_IDLE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Bench for bresenham_line_engine: directed lines from the test plan plus
// random endpoints with random backpressure, compared against an
// integer-arithmetic line model.
module tb_bresenham_line_engine;
    import bla_pkg::*;

    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           draw_en;
    logic [CW-1:0]  x0, y0, x1, y1;
    logic           draw_done;
    logic           busy;
    bla_eng_state_t state_dbg;

    bresenham_line_engine_if #(.COORD_W(CW)) pix ();

    bresenham_line_engine #(.COORD_W(CW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .draw_en   (draw_en),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .draw_done (draw_done),
        .busy      (busy),
        .state_dbg (state_dbg),
        .pix       (pix)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard: pixels packed as {x, y}
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int first_cyc, done_cyc, unstable, extra_pix, timed_out;

    // Reference line: integer Bresenham straight from the algorithm text.
    function automatic void model_line(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, x, y;
        exp_q.delete();
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        for (int n = 0; n < 1000; n++) begin
            exp_q.push_back({x[7:0], y[7:0]});
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    function automatic int max_len(input int ax0, input int ay0, input int ax1, input int ay1);
        int adx, ady;
        adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
        return ((adx > ady) ? adx : ady) + 1;
    endfunction

    // Driver: one controller-style request. Cycle 0 is the cycle draw_en is
    // first high; done_cyc is the cycle draw_done is seen. draw_en drops the
    // cycle after done, so a following call raises it one cycle later.
    task automatic drive_line(input int ax0, input int ay0, input int ax1, input int ay1,
                              input int stall_pct, input int hold_x, input int hold_y,
                              input int hold_len);
        int          cyc;
        int          hold_left;
        logic        prev_stall;
        logic [15:0] prev_pix;
        logic        rdy;
        obs_q.delete();
        first_cyc  = -1;
        done_cyc   = -1;
        unstable   = 0;
        extra_pix  = 0;
        timed_out  = 0;
        cyc        = 0;
        hold_left  = hold_len;
        prev_stall = 1'b0;
        prev_pix   = '0;
        @(negedge clk);
        x0 = ax0[7:0]; y0 = ay0[7:0]; x1 = ax1[7:0]; y1 = ay1[7:0];
        draw_en = 1'b1;
        pix.pix_ready = 1'b1;
        while (done_cyc < 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (draw_done) begin
                done_cyc = cyc;
                if (pix.pix_wr) extra_pix++;
            end else if (pix.pix_wr) begin
                if (prev_stall && {pix.px, pix.py} !== prev_pix) unstable++;
                if (first_cyc < 0) first_cyc = cyc;
                rdy = 1'b1;
                if (hold_left > 0 && pix.px == hold_x[7:0] && pix.py == hold_y[7:0]) begin
                    rdy = 1'b0;
                    hold_left--;
                end else if ($urandom_range(99) < stall_pct) begin
                    rdy = 1'b0;
                end
                pix.pix_ready = rdy;
                if (rdy) obs_q.push_back({pix.px, pix.py});
                prev_stall = !rdy;
                prev_pix   = {pix.px, pix.py};
            end else begin
                pix.pix_ready = 1'($urandom_range(1));
                prev_stall = 1'b0;
            end
        end
        if (done_cyc < 0) timed_out = 1;
        @(negedge clk);
        if (pix.pix_wr || draw_done) extra_pix++;
        draw_en = 1'b0;
        pix.pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        draw_en = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        pix.pix_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pix.pix_wr, draw_done, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got wr/done/busy=%b exp 000", {pix.pix_wr, draw_done, busy});
        end
        checks++;
        if ({pix.px, pix.py} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pix got %h exp 0000", {pix.px, pix.py});
        end
        n_rst = 1'b1;
        @(negedge clk);
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", state_dbg, ST_IDLE);
        end
    endtask

    task automatic test_horizontal();
        exp_q = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
        drive_line(0, 0, 3, 0, 0, 0, 0, 0);
        checks++;
        if (timed_out !== 0) begin errors++; $display("FAIL horiz_timeout got %0d exp 0", timed_out); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL horiz_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL horiz_pix[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (first_cyc !== 2) begin errors++; $display("FAIL horiz_first_cycle got %0d exp 2", first_cyc); end
        checks++;
        if (done_cyc !== 6) begin errors++; $display("FAIL horiz_done_cycle got %0d exp 6", done_cyc); end
        checks++;
        if (extra_pix !== 0) begin errors++; $display("FAIL horiz_extra got %0d exp 0", extra_pix); end
    endtask

    task automatic test_steep();
        exp_q = '{16'h0205, 16'h0204, 16'h0103, 16'h0102, 16'h0001, 16'h0000};
        drive_line(2, 5, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs_q.size() !== 6) begin
            errors++; $display("FAIL steep_count got %0d exp 6", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL steep_pix[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cyc !== 8) begin errors++; $display("FAIL steep_done_cycle got %0d exp 8", done_cyc); end
    endtask

    task automatic test_single();
        drive_line(7, 7, 7, 7, 0, 0, 0, 0);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL single_count got %0d exp 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 16'h0707) begin
                errors++; $display("FAIL single_pix got %h exp 0707", obs_q[0]);
            end
        end
        checks++;
        if (first_cyc !== 2) begin errors++; $display("FAIL single_first_cycle got %0d exp 2", first_cyc); end
        checks++;
        if (done_cyc !== 3) begin errors++; $display("FAIL single_done_cycle got %0d exp 3", done_cyc); end
    endtask

    task automatic test_backpressure();
        exp_q = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
        drive_line(0, 0, 3, 0, 0, 1, 0, 3);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL bp_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_pix[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
        checks++;
        if (done_cyc !== 9) begin errors++; $display("FAIL bp_done_cycle got %0d exp 9", done_cyc); end
    endtask

    task automatic test_abort();
        int n;
        int cyc;
        int done_seen;
        n = 0; cyc = 0; done_seen = 0;
        @(negedge clk);
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd20; y1 = 8'd7;
        draw_en = 1'b1;
        pix.pix_ready = 1'b1;
        while (n < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (pix.pix_wr) n++;
        end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL abort_reach_plot got %0d pixels exp 3", n); end
        draw_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({pix.pix_wr, busy} !== 2'b00) begin
            errors++; $display("FAIL abort_stop got wr/busy=%b exp 00", {pix.pix_wr, busy});
        end
        repeat (20) begin
            @(negedge clk);
            if (draw_done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", done_seen); end
    endtask

    task automatic test_reset_mid();
        int n;
        int cyc;
        n = 0; cyc = 0;
        @(negedge clk);
        x0 = 8'd50; y0 = 8'd10; x1 = 8'd5; y1 = 8'd40;
        draw_en = 1'b1;
        pix.pix_ready = 1'b1;
        while (n < 4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (pix.pix_wr) n++;
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({pix.pix_wr, draw_done, busy} !== 3'b000 || {pix.px, pix.py} !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_outputs got wr/done/busy=%b pix=%h exp 000 0000",
                     {pix.pix_wr, draw_done, busy}, {pix.px, pix.py});
        end
        draw_en = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({draw_done, busy} !== 2'b00) begin
            errors++; $display("FAIL rst_mid_after got done/busy=%b exp 00", {draw_done, busy});
        end
    endtask

    task automatic test_back_to_back();
        model_line(3, 9, 12, 4);
        drive_line(3, 9, 12, 4, 0, 0, 0, 0);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL b2b_first_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        // Second request arrives exactly one cycle after draw_en dropped.
        model_line(0, 0, 255, 255);
        drive_line(0, 0, 255, 255, 0, 0, 0, 0);
        checks++;
        if (first_cyc !== 2) begin errors++; $display("FAIL b2b_start got %0d exp 2", first_cyc); end
        checks++;
        if (obs_q.size() !== 256) begin
            errors++; $display("FAIL full_count got %0d exp 256", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== {i[7:0], i[7:0]}) begin
                errors++; $display("FAIL full_pix[%0d] got %h exp %h", i, obs_q[i], {i[7:0], i[7:0]});
            end
        end
        checks++;
        if (done_cyc !== 258) begin errors++; $display("FAIL full_done_cycle got %0d exp 258", done_cyc); end
        checks++;
        if (extra_pix !== 0) begin errors++; $display("FAIL b2b_extra got %0d exp 0", extra_pix); end
    endtask

    task automatic test_random();
        int ax0, ay0, ax1, ay1;
        for (int t = 0; t < 14; t++) begin
            if (t == 0) begin ax0 = 255; ay0 = 0; ax1 = 0; ay1 = 255; end
            else if (t == 1) begin ax0 = 0; ay0 = 255; ax1 = 255; ay1 = 3; end
            else begin
                ax0 = $urandom_range(255); ay0 = $urandom_range(255);
                ax1 = $urandom_range(255); ay1 = $urandom_range(255);
            end
            model_line(ax0, ay0, ax1, ay1);
            drive_line(ax0, ay0, ax1, ay1, 30, 0, 0, 0);
            checks++;
            if (timed_out !== 0) begin errors++; $display("FAIL rand%0d_timeout got %0d exp 0", t, timed_out); end
            checks++;
            if (obs_q.size() !== max_len(ax0, ay0, ax1, ay1)) begin
                errors++;
                $display("FAIL rand%0d_count got %0d exp %0d", t, obs_q.size(), max_len(ax0, ay0, ax1, ay1));
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_pix[%0d] got %h exp %h", t, i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (unstable !== 0 || extra_pix !== 0) begin
                errors++;
                $display("FAIL rand%0d_hs got unstable=%0d extra=%0d exp 0 0", t, unstable, extra_pix);
            end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_steep();
        test_single();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
